// File: rtl/vga_plot_engine_pkg.sv
// Shared widths, screen defaults, FSM encoding and FIFO entry layout for the VGA plot engine.
package vga_plot_engine_pkg;

    localparam int unsigned COLOR_W      = 15;
    localparam int unsigned X_W          = 8;
    localparam int unsigned Y_W          = 7;
    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;
    localparam int unsigned ENTRY_W      = 1 + COLOR_W + Y_W + X_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDraw  = 2'd1,
        StClear = 2'd2
    } state_e;

    typedef struct packed {
        logic               clear;
        logic [COLOR_W-1:0] color;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     x;
    } entry_t;

    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                      input int unsigned w, input int unsigned h);
        return (32'(x) < w) && (32'(y) < h);
    endfunction

endpackage

// File: rtl/vga_plot_engine_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap naturally.
module vga_plot_engine_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 31
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vga_plot_engine.sv
// Buffers plot/clear requests and emits one registered pixel write per accepted cycle.
module vga_plot_engine
    import vga_plot_engine_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_clear,
    input  logic [X_W-1:0]     req_x,
    input  logic [Y_W-1:0]     req_y,
    input  logic [COLOR_W-1:0] req_color,
    input  logic               out_ready,
    output logic               plot,
    output logic [X_W-1:0]     out_x,
    output logic [Y_W-1:0]     out_y,
    output logic [COLOR_W-1:0] out_color,
    output logic               busy,
    output logic               clip_error
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    state_e             state_q, state_d;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     out_x_q, out_x_d;
    logic [Y_W-1:0]     out_y_q, out_y_d;
    logic [COLOR_W-1:0] out_color_q, out_color_d;
    logic [X_W-1:0]     x_cnt_q, x_cnt_d;
    logic [Y_W-1:0]     y_cnt_q, y_cnt_d;
    logic               clip_q, clip_d;

    logic                       accept, clipped, fifo_push, fifo_pop, take_next;
    logic                       fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]         fifo_rdata;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    entry_t                     head;

    // Clipped plots still complete the handshake; they just never reach the FIFO.
    assign req_ready = ~reset & ~fifo_full;
    assign accept    = req_valid & req_ready;
    assign clipped   = ~req_clear & ~in_range(req_x, req_y, SCREEN_W, SCREEN_H);
    assign fifo_push = accept & ~clipped;
    assign clip_d    = clip_q | (accept & clipped);
    assign head      = entry_t'(fifo_rdata);

    vga_plot_engine_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_clear, req_color, req_y, req_x}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        plot_d      = plot_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_color_d = out_color_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        fifo_pop    = 1'b0;
        take_next   = 1'b0;

        unique case (state_q)
            StIdle: take_next = 1'b1;
            StDraw: take_next = out_ready;
            StClear: begin
                if (out_ready) begin
                    if (x_cnt_q == X_LAST) begin
                        if (y_cnt_q == Y_LAST) begin
                            take_next = 1'b1;
                        end else begin
                            x_cnt_d = '0;
                            y_cnt_d = y_cnt_q + 1'b1;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + 1'b1;
                    end
                    out_x_d = x_cnt_d;
                    out_y_d = y_cnt_d;
                end
            end
            default: state_d = StIdle;
        endcase

        // Shared by IDLE and by DRAW/CLEAR completion so back-to-back pixels have no bubble.
        if (take_next) begin
            if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                plot_d      = 1'b1;
                out_color_d = head.color;
                if (head.clear) begin
                    state_d = StClear;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                    out_x_d = '0;
                    out_y_d = '0;
                end else begin
                    state_d = StDraw;
                    out_x_d = head.x;
                    out_y_d = head.y;
                end
            end else begin
                state_d = StIdle;
                plot_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            plot_q      <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_color_q <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            plot_q      <= plot_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_color_q <= out_color_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            clip_q      <= clip_d;
        end
    end

    assign plot       = plot_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_color  = out_color_q;
    assign clip_error = clip_q;
    assign busy       = (fifo_count != '0) | (state_q != StIdle);

endmodule

// File: tb/tb_vga_plot_engine.sv
// Directed bench for vga_plot_engine: plot latency, stalls, FIFO fill, clipping, clear, reset abort.
module tb_vga_plot_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_clear;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [14:0] req_color;
    logic        out_ready;
    logic        plot;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [14:0] out_color;
    logic        busy;
    logic        clip_error;

    int total = 0;
    int bad   = 0;

    vga_plot_engine #(
        .DEPTH    (4),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_clear  (req_clear),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .out_ready  (out_ready),
        .plot       (plot),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_color  (out_color),
        .busy       (busy),
        .clip_error (clip_error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic clr, input logic [7:0] x, input logic [6:0] y,
                           input logic [14:0] c);
        req_valid = 1'b1;
        req_clear = clr;
        req_x     = x;
        req_y     = y;
        req_color = c;
    endtask

    initial begin
        int n;
        int lx;
        int ly;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_clear = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_clip", 32'(clip_error), 0);
        check("rst_ready_forced_low", 32'(req_ready), 0);
        check("rst_out_x", 32'(out_x), 0);
        check("rst_color", 32'(out_color), 0);
        reset = 1'b0;
        step();
        check("ready_after_rst", 32'(req_ready), 1);

        // 1: single plot, latency N+1, one-cycle strobe
        out_ready = 1'b1;
        set_req(1'b0, 8'd5, 7'd7, 15'h7C00);
        step();
        req_valid = 1'b0;
        check("t1_plot_at_N", 32'(plot), 0);
        check("t1_busy_at_N", 32'(busy), 1);
        step();
        check("t1_plot", 32'(plot), 1);
        check("t1_x", 32'(out_x), 5);
        check("t1_y", 32'(out_y), 7);
        check("t1_color", 32'(out_color), 32'h7C00);
        step();
        check("t1_plot_drop", 32'(plot), 0);
        check("t1_busy_drop", 32'(busy), 0);

        // 2: stall three cycles
        out_ready = 1'b0;
        set_req(1'b0, 8'd10, 7'd20, 15'h1234);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_plot_hold", 32'(plot), 1);
            check("t2_x_hold", 32'(out_x), 10);
            check("t2_y_hold", 32'(out_y), 20);
            check("t2_color_hold", 32'(out_color), 32'h1234);
        end
        out_ready = 1'b1;
        step();
        check("t2_plot_done", 32'(plot), 0);
        check("t2_busy_done", 32'(busy), 0);

        // 3: blocker pixel stalls in DRAW, then six requests fill the 4-entry FIFO
        out_ready = 1'b0;
        set_req(1'b0, 8'd100, 7'd50, 15'h0AAA);
        step();
        req_valid = 1'b0;
        step();
        check("t3_blocker_x", 32'(out_x), 100);
        for (int k = 0; k < 6; k++) begin
            set_req(1'b0, 8'(k + 1), 7'(k + 2), 15'(k + 16'h0100));
            check("t3_ready", 32'(req_ready), (k < 4) ? 1 : 0);
            step();
        end
        req_valid = 1'b0;
        check("t3_ready_full", 32'(req_ready), 0);
        check("t3_still_blocker", 32'(out_x), 100);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_seq_plot", 32'(plot), 1);
            check("t3_seq_x", 32'(out_x), k + 1);
            check("t3_seq_y", 32'(out_y), k + 2);
            check("t3_seq_color", 32'(out_color), k + 32'h0100);
        end
        step();
        check("t3_plot_end", 32'(plot), 0);
        check("t3_busy_end", 32'(busy), 0);

        // 4: clipping, plus the in-range corner pixel
        set_req(1'b0, 8'd160, 7'd0, 15'h7FFF);
        step();
        check("t4_clip_set", 32'(clip_error), 1);
        set_req(1'b0, 8'd0, 7'd120, 15'h7FFF);
        step();
        req_valid = 1'b0;
        check("t4_no_plot", 32'(plot), 0);
        step();
        check("t4_no_plot2", 32'(plot), 0);
        check("t4_not_busy", 32'(busy), 0);
        set_req(1'b0, 8'd159, 7'd119, 15'h0321);
        step();
        req_valid = 1'b0;
        step();
        check("t4_corner_plot", 32'(plot), 1);
        check("t4_corner_x", 32'(out_x), 159);
        check("t4_corner_y", 32'(out_y), 119);
        step();
        check("t4_clip_sticky", 32'(clip_error), 1);

        // 5: full clear
        set_req(1'b1, 8'd0, 7'd0, 15'h001F);
        step();
        req_valid = 1'b0;
        step();
        n  = 0;
        lx = -1;
        ly = -1;
        for (int c = 0; c < 20000 && plot; c++) begin
            if (n == 0) begin
                check("t5_first_x", 32'(out_x), 0);
                check("t5_first_y", 32'(out_y), 0);
                check("t5_color", 32'(out_color), 32'h001F);
            end else if (n == 1) begin
                check("t5_second_x", 32'(out_x), 1);
                check("t5_second_y", 32'(out_y), 0);
            end else if (n == 160) begin
                check("t5_161st_x", 32'(out_x), 0);
                check("t5_161st_y", 32'(out_y), 1);
            end
            lx = int'(out_x);
            ly = int'(out_y);
            n++;
            step();
        end
        check("t5_count", 32'(n), 19200);
        check("t5_last_x", 32'(lx), 159);
        check("t5_last_y", 32'(ly), 119);
        check("t5_busy_after", 32'(busy), 0);

        // 6: reset during a clear with two plots queued
        set_req(1'b1, 8'd0, 7'd0, 15'h03E0);
        step();
        set_req(1'b0, 8'd3, 7'd4, 15'h0011);
        step();
        set_req(1'b0, 8'd6, 7'd8, 15'h0022);
        step();
        req_valid = 1'b0;
        n = 2;
        for (int c = 0; c < 2000 && n < 500; c++) begin
            if (plot) n++;
            step();
        end
        check("t6_reached_500", 32'(n), 500);
        check("t6_clear_active", 32'(plot), 1);
        reset = 1'b1;
        step();
        check("t6_rst_plot", 32'(plot), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_clip", 32'(clip_error), 0);
        check("t6_rst_ready", 32'(req_ready), 0);
        reset = 1'b0;
        step();
        check("t6_ready_again", 32'(req_ready), 1);
        check("t6_fifo_empty", 32'(busy), 0);
        step();
        check("t6_no_resume", 32'(plot), 0);
        set_req(1'b0, 8'd42, 7'd11, 15'h5555);
        step();
        req_valid = 1'b0;
        step();
        check("t6_new_plot", 32'(plot), 1);
        check("t6_new_x", 32'(out_x), 42);
        check("t6_new_y", 32'(out_y), 11);
        check("t6_new_color", 32'(out_color), 32'h5555);
        step();
        check("t6_new_done", 32'(plot), 0);
        check("t6_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
